// File: rtl/load_store_unit_if.sv
// Core/RAM-facing signal bundle of the load/store unit.
// master: datapath + data RAM side; slave: the load_store_unit itself.
interface load_store_unit_if #(
    parameter int unsigned MEM_ADDR_BITS = 12
);
    logic                     req;
    logic                     we;
    logic [2:0]               funct3;
    logic [31:0]              addr;
    logic [31:0]              wdata;
    logic                     ready;
    logic                     done;
    logic                     fault;
    logic [31:0]              rdata;
    logic                     mem_en;
    logic                     mem_we;
    logic [3:0]               mem_be;
    logic [MEM_ADDR_BITS-1:0] mem_addr;
    logic [31:0]              mem_wdata;
    logic [31:0]              mem_rdata;

    modport master (
        output req, we, funct3, addr, wdata, mem_rdata,
        input  ready, done, fault, rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        input  req, we, funct3, addr, wdata, mem_rdata,
        output ready, done, fault, rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-request data-memory access engine: alignment check, byte lanes,
// load extension and a one-cycle completion pulse for the control FSM.
module load_store_unit #(
    parameter int unsigned MEM_ADDR_BITS = 12,
    parameter int unsigned READ_LATENCY  = 1
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);
    localparam int unsigned CNT_W = 2;
    localparam int unsigned OFF_W = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     we_q, we_d;
    logic [2:0]               f3_q, f3_d;
    logic [OFF_W-1:0]         off_q, off_d;

    logic                     ready_q, ready_d;
    logic                     done_q, done_d;
    logic                     fault_q, fault_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     mem_en_q, mem_en_d;
    logic                     mem_we_q, mem_we_d;
    logic [3:0]               mem_be_q, mem_be_d;
    logic [MEM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]              mem_wdata_q, mem_wdata_d;

    logic                     illegal_c;
    logic                     unused_addr_bits;

    // Address bits above the RAM word address wrap silently.
    assign unused_addr_bits = ^bus.addr[31:MEM_ADDR_BITS+2];

    assign illegal_c = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11)
                    || (bus.we && bus.funct3[2])
                    || ((bus.funct3[1:0] == 2'b01) && bus.addr[0])
                    || ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [OFF_W-1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [OFF_W-1:0] off,
                                            input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return d;
        endcase
    endfunction

    // State, request latches and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next state, latency counter and request latches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    f3_d    = bus.funct3;
                    off_d   = bus.addr[OFF_W-1:0];
                    state_d = illegal_c ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the next state.
    always_comb begin
        ready_d     = (state_d == IDLE);
        done_d      = (state_d == DONE);
        mem_en_d    = (state_d == ACCESS);
        mem_we_d    = (state_d == ACCESS) && we_d;
        fault_d     = fault_q;
        rdata_d     = rdata_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        // Only an IDLE->DONE hop is a faulted request; fault holds between dones.
        if (state_d == DONE) fault_d = (state_q == IDLE) ? illegal_c : 1'b0;
        if ((state_q == WAIT) && (cnt_q == '0)) rdata_d = extract(f3_q, off_q, bus.mem_rdata);
        if ((state_q == IDLE) && bus.req) begin
            mem_be_d    = lane_be(bus.funct3, bus.addr[OFF_W-1:0]);
            mem_addr_d  = bus.addr[MEM_ADDR_BITS+1:2];
            mem_wdata_d = lane_wdata(bus.funct3, bus.wdata);
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: two load_store_unit instances (READ_LATENCY 1 and 3)
// share stimulus; each has its own latency-pipelined RAM and completion monitor.
module tb_load_store_unit;
    localparam int unsigned MAB   = 12;
    localparam int unsigned WORDS = 1 << MAB;

    typedef struct packed {
        logic           ready;
        logic           done;
        logic           fault;
        logic [31:0]    rdata;
        logic           mem_en;
        logic           mem_we;
        logic [3:0]     mem_be;
        logic [MAB-1:0] mem_addr;
        logic [31:0]    mem_wdata;
    } obs_t;

    typedef struct {
        logic        fault;
        logic        is_load;
        logic [31:0] rdata;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    obs_t        obs [2];
    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    logic [31:0] ref_mem [WORDS];
    logic [31:0] last_rdata = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int unsigned RL = (g == 0) ? 1 : 3;
        load_store_unit_if #(.MEM_ADDR_BITS(MAB)) bus ();
        logic [31:0] ram [WORDS];
        logic [31:0] pipe [4];
        int          en_cnt = 0;

        assign bus.req    = req;
        assign bus.we     = we;
        assign bus.funct3 = funct3;
        assign bus.addr   = addr;
        assign bus.wdata  = wdata;
        assign bus.mem_rdata = pipe[RL-1];
        assign obs[g] = {bus.ready, bus.done, bus.fault, bus.rdata, bus.mem_en, bus.mem_we,
                         bus.mem_be, bus.mem_addr, bus.mem_wdata};

        load_store_unit #(.MEM_ADDR_BITS(MAB), .READ_LATENCY(RL)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        initial for (int i = 0; i < WORDS; i++) ram[i] <= '0;

        // RAM: byte-enabled write, read data emerges RL edges after the enable edge.
        always @(posedge clk) begin
            if (bus.mem_en && bus.mem_we)
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            pipe[0] <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr] : $urandom;
            for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
        end

        always @(negedge clk) begin
            exp_t e;
            int   lat;
            logic have;
            if (reset) begin
                en_cnt = 0;
            end else begin
                if (bus.mem_en) en_cnt++;
                if (bus.done) begin
                    have = (g == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
                    if (!have) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_done lane%0d: done with nothing outstanding (cycle %0d)", g, cyc);
                    end else begin
                        if (g == 0) e = exp_q0.pop_front();
                        else        e = exp_q1.pop_front();
                        lat = e.fault ? 1 : (e.is_load ? RL + 2 : 2);
                        check($sformatf("fault_lane%0d", g), 96'(bus.fault), 96'(e.fault));
                        check($sformatf("rdata_lane%0d", g), 96'(bus.rdata), 96'(e.rdata));
                        check($sformatf("latency_lane%0d", g), 96'(cyc - e.acc + 1), 96'(lat));
                        check($sformatf("mem_en_cycles_lane%0d", g), 96'(en_cnt), 96'(e.fault ? 0 : 1));
                    end
                    en_cnt = 0;
                end
            end
        end
    end

    // Issue one request at a negedge once both units are ready; returns two negedges later.
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int          waited;
        int unsigned n, off, idx;
        logic        ill;
        logic [31:0] word, val, exp_wd, mask;
        logic [3:0]  exp_be;
        waited = 0;
        while (!(obs[0].ready && obs[1].ready) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: ready still low after %0d cycles", waited);
        end
        n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off = a % 4;
        idx = (a / 4) % WORDS;
        ill = (f3 == 3'd3) || (f3 >= 3'd6) || (w && f3 >= 3'd4) || ((a % n) != 0);
        word   = ref_mem[idx];
        exp_be = 4'(((1 << n) - 1) << off);
        exp_wd = (n == 1) ? (d & 32'hFF) * 32'h0101_0101 :
                 (n == 2) ? (d & 32'hFFFF) * 32'h0001_0001 : d;
        e.fault   = ill;
        e.is_load = !w;
        e.rdata   = last_rdata;
        e.acc     = cyc + 1;
        if (!ill) begin
            if (w) begin
                for (int i = 0; i < n; i++) word[8*(off+i) +: 8] = d[8*i +: 8];
                ref_mem[idx] = word;
            end else begin
                val = word >> (8 * off);
                if (n < 4) begin
                    mask = (32'd1 << (8 * n)) - 1;
                    val  = val & mask;
                    if (f3 < 3'd4 && val[8*n-1]) val = val | ~mask;
                end
                e.rdata    = val;
                last_rdata = val;
            end
        end
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
        exp_q0.push_back(e);
        exp_q1.push_back(e);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (ill)
                check($sformatf("no_access_lane%0d", k), 96'(obs[k].mem_en), 96'(0));
            else
                check($sformatf("access_lane%0d", k),
                      96'({obs[k].mem_en, obs[k].mem_we, obs[k].mem_be, obs[k].mem_addr, obs[k].mem_wdata}),
                      96'({1'b1, w, exp_be, MAB'(idx), exp_wd}));
        end
        // Sometimes keep req high with junk while busy: it must be ignored.
        if ($urandom_range(1) == 1) begin
            we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        end else begin
            req = 1'b0;
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        obs_t        reset_obs;
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        int          waited;
        reset_obs       = '0;
        reset_obs.ready = 1'b1;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) check($sformatf("reset_lane%0d", k), 96'(obs[k]), 96'(reset_obs));
        reset = 1'b0;
        @(negedge clk);

        issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
        issue(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5);
        issue(1'b0, 3'b000, 32'h0000_0013, 32'h0);
        issue(1'b0, 3'b100, 32'h0000_0013, 32'h0);
        issue(1'b1, 3'b001, 32'h0000_0022, 32'h0000_8001);
        issue(1'b0, 3'b001, 32'h0000_0022, 32'h0);
        issue(1'b0, 3'b101, 32'h0000_0022, 32'h0);
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        issue(1'b0, 3'b010, 32'h0000_0006, 32'h0);
        issue(1'b1, 3'b001, 32'h0000_0001, 32'h1234_5678);
        issue(1'b0, 3'b011, 32'h0000_0040, 32'h0);
        issue(1'b1, 3'b100, 32'h0000_0040, 32'h0000_0077);
        issue(1'b0, 3'b010, 32'hFFFF_C010, 32'h0);

        for (int t = 0; t < 250; t++) begin
            w  = 1'($urandom);
            f3 = 3'($urandom);
            case ($urandom_range(5))
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                4: f3 = 3'b101;
                default: ;
            endcase
            a = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(63));
            issue(w, f3, a, $urandom);
            repeat ($urandom_range(2)) @(negedge clk);
        end

        // Reset while both units sit in WAIT: no done, outputs back to reset values at once.
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("midwait_reset_lane%0d", k), 96'(obs[k]), 96'(reset_obs));
        exp_q0.delete();
        exp_q1.delete();
        last_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);

        waited = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("drain_outstanding", 96'(exp_q0.size() + exp_q1.size()), 96'(0));
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access engine for the multicycle RV32I core. It sits between the datapath's address/store-data registers and the synchronous single-port data RAM. It accepts one load or store request at a time and handles byte-lane alignment, byte enables and load sign/zero extension. It returns a registered, extended load value together with a one-cycle completion pulse for the control FSM.

## Interface
- MEM_ADDR_BITS, default 12: word-address width of the RAM (4 KiB words); mem_addr = addr[MEM_ADDR_BITS+1:2].
- READ_LATENCY, default 1: cycles from RAM enable edge to valid mem_rdata; legal range 1..4.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  reset, asynchronous, active-high; clock clk.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only).
- addr  in  32  byte address (ALUOut).
- wdata  in  32  store data (register B).
- ready  out  1  1 when in IDLE.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with done; 1 = misaligned or illegal funct3, no RAM access made.
- rdata  out  32  extended load result; holds until the next successful load completes.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_be  out  4  byte enables, bit i = bits [8i+7:8i].
- mem_addr  out  MEM_ADDR_BITS  RAM word address.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  RAM read data.

## Operation
- States: IDLE, ACCESS, WAIT, DONE. Reset state is IDLE.
- IDLE: ready=1. When req=1, latch addr, wdata, funct3 and we, then check legality.
  - Illegal: funct3 in {011, 110, 111}; or we=1 with funct3 in {100, 101}; or H/HU with addr[0]=1; or W with addr[1:0]≠00.
  - Illegal requests go to DONE with fault latched to 1.
  - Legal requests go to ACCESS with fault latched to 0.
- ACCESS: mem_en=1 and mem_we=we_latched for exactly one cycle.
  - Store: next state DONE.
  - Load: next state WAIT, with the counter loaded to READ_LATENCY-1.
- WAIT: when the counter is 0, capture the extracted mem_rdata into rdata and go to DONE; otherwise decrement the counter.
- DONE: done=1 for one cycle, then go to IDLE.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: 0011 if addr[1]=0, else 1100.
  - W: 1111.
  - Driven identically for loads and stores; only meaningful while mem_en=1.
- mem_wdata: B gives {4{wdata[7:0]}}, H gives {2{wdata[15:0]}}, W gives wdata.
- Load extraction:
  - Select the byte by addr[1:0], or the half by addr[1].
  - B/H are sign-extended; BU/HU are zero-extended; W passes through unchanged.
- mem_addr comes from latched addr and is stable from ACCESS through DONE. Upper address bits beyond MEM_ADDR_BITS+1 are ignored, so addresses wrap.
- req outside IDLE is ignored; there is no queueing.
- Stores and faulted requests never modify rdata.

## Timing
- Reset values: ready=1, done=0, fault=0, rdata=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- With req accepted at edge 0:
  - Store: ACCESS in cycle 1, done in cycle 2.
  - Load: ACCESS in cycle 1, WAIT in cycles 2..READ_LATENCY+1, done and new rdata visible in cycle READ_LATENCY+2.
  - Fault: done=1, fault=1 in cycle 1.
- mem_rdata is sampled on the edge ending the last WAIT cycle, i.e. READ_LATENCY cycles after the ACCESS edge.
- done and fault are registered outputs; fault is held until the next done.
- ready falls the cycle after the accepting edge and rises in the cycle after DONE. Back-to-back requests are therefore spaced at least store 3 / load READ_LATENCY+3 cycles apart.
- Reset asserted mid-operation:
  - Immediately forces IDLE and drives all outputs to their reset values.
  - An in-flight store whose ACCESS cycle had not yet occurred is never written.
  - No done pulse is issued.

## Test plan
- SW at addr 0x0000_0010, wdata 0xDEAD_BEEF -> cycle 1: mem_en=1, mem_we=1, mem_be=1111, mem_addr=4, mem_wdata=0xDEAD_BEEF; done=1, fault=0 in cycle 2.
- SB at 0x13, wdata 0x0000_00A5 -> mem_be=1000, mem_wdata=0xA5A5_A5A5; then LB at 0x13 returns rdata=0xFFFF_FFA5 and LBU returns 0x0000_00A5, each with done at cycle READ_LATENCY+2.
- SH at 0x22, wdata 0x0000_8001 -> mem_be=1100; LH at 0x22 returns 0xFFFF_8001 and LHU returns 0x0000_8001; run with READ_LATENCY=1 and 3 to check done timing.
- LW at 0x06 -> done=1, fault=1 in cycle 1, mem_en never asserted, rdata unchanged. Repeat with SH at 0x01 and funct3=011: both fault.
- Pulse req while in ACCESS/WAIT -> ignored, exactly one done. Assert reset during WAIT -> outputs go to reset values asynchronously, no done; a following LW completes normally.
